// File: rtl/tpu_job_sequencer.sv
// Host-side sequencer: loads one A/B job into tpuv1, starts it, waits, streams C back out.
// Latency: 1 cycle from input accept to tpuv1 write; C readback begins COMPUTE_CYCLES+1 after start.
// Backpressure: in_ready only in LOAD; each result word holds (with addr) until out_ready. Macro: C_CLEAR_EN.
module tpu_job_sequencer #(
   parameter int DIM            = 8,
   parameter int BITS_AB        = 8,
   parameter int BITS_C         = 16,
   parameter int ADDRW          = 16,
   parameter int DATAW          = 64,
   parameter int COMPUTE_CYCLES = 32,
   parameter int A_BASE         = 'h100,
   parameter int B_BASE         = 'h200,
   parameter int C_BASE         = 'h300,
   parameter int START_ADDR     = 'h400
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DATAW-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DATAW-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic [ADDRW-1:0] addr,
   output logic             r_w,
   output logic [DATAW-1:0] dataIn,
   input  logic [DATAW-1:0] dataOut
);

   localparam int NIN  = 2 * DIM;
   localparam int NOUT = DIM * DIM * BITS_C / DATAW;
   localparam int CMAX = (NIN > NOUT) ? ((NIN > COMPUTE_CYCLES) ? NIN : COMPUTE_CYCLES)
                                      : ((NOUT > COMPUTE_CYCLES) ? NOUT : COMPUTE_CYCLES);
   localparam int CNTW = $clog2(CMAX + 1);

   localparam logic [ADDRW-1:0] A_B = ADDRW'(A_BASE);
   localparam logic [ADDRW-1:0] B_B = ADDRW'(B_BASE);
   localparam logic [ADDRW-1:0] C_B = ADDRW'(C_BASE);
   localparam logic [ADDRW-1:0] S_A = ADDRW'(START_ADDR);

   // A bus word packs exactly one row of A/B elements; C words must tile the result evenly.
   generate
      if (DATAW != DIM * BITS_AB) begin : g_bad_dataw
         $error("tpu_job_sequencer: DATAW must equal DIM*BITS_AB");
      end
      if ((DIM * DIM * BITS_C) % DATAW != 0) begin : g_bad_nout
         $error("tpu_job_sequencer: C matrix must be a whole number of bus words");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_START, S_WAIT, S_READ
   } state_t;

   state_t          state;
   logic [CNTW-1:0] cnt;

   // Word offset to byte address: every tpuv1 word is 8 bytes apart.
   function automatic logic [ADDRW-1:0] off8(input logic [CNTW-1:0] n);
      return ADDRW'(n) << 3;
   endfunction

   // Job FSM; every output is a register that already holds the current cycle's bus action.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         addr      <= '0;
         r_w       <= 1'b0;
         dataIn    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               r_w       <= 1'b0;
               addr      <= '0;
               dataIn    <= '0;
               cnt       <= '0;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
               if (in_valid) begin
                  busy <= 1'b1;
`ifdef C_CLEAR_EN
                  state <= S_CLEAR;
                  r_w   <= 1'b1;
                  addr  <= C_B;
`else
                  state    <= S_LOAD;
                  in_ready <= 1'b1;
`endif
               end
            end
`ifdef C_CLEAR_EN
            S_CLEAR: begin
               if (cnt == CNTW'(NOUT - 1)) begin
                  state    <= S_LOAD;
                  r_w      <= 1'b0;
                  addr     <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b1;
               end else begin
                  cnt  <= cnt + 1'b1;
                  addr <= C_B + off8(cnt + 1'b1);
               end
            end
`endif
            S_LOAD: begin
               if (!in_ready) begin
                  // The last row is on the bus this cycle; follow it with the start write.
                  state  <= S_START;
                  r_w    <= 1'b1;
                  addr   <= S_A;
                  dataIn <= '0;
               end else if (in_valid) begin
                  // Rows arrive interleaved A0,B0,A1,B1,...; tpuv1 shifts every B row in at one address.
                  r_w    <= 1'b1;
                  dataIn <= in_data;
                  addr   <= cnt[0] ? B_B : (A_B + off8(cnt >> 1));
                  cnt    <= cnt + 1'b1;
                  if (cnt == CNTW'(NIN - 1)) in_ready <= 1'b0;
               end else begin
                  r_w    <= 1'b0;
                  addr   <= '0;
                  dataIn <= '0;
               end
            end
            S_START: begin
               state <= S_WAIT;
               r_w   <= 1'b0;
               addr  <= '0;
               cnt   <= '0;
            end
            S_WAIT: begin
               if (cnt == CNTW'(COMPUTE_CYCLES - 1)) begin
                  state <= S_READ;
                  addr  <= C_B;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_READ: begin
               if (!out_valid) begin
                  // Address was presented last cycle, so dataOut is settled now.
                  out_data  <= dataOut;
                  out_valid <= 1'b1;
                  out_last  <= (cnt == CNTW'(NOUT - 1));
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (cnt == CNTW'(NOUT - 1)) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                     addr  <= '0;
                     cnt   <= '0;
                  end else begin
                     cnt  <= cnt + 1'b1;
                     addr <= C_B + off8(cnt + 1'b1);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Bench for tpu_job_sequencer with a behavioural tpuv1 memory model and a matrix-level reference.
// Latency: checks the compute window and per-word write timing against the accept cycle.
// Backpressure: randomised out_ready and gapped in_valid; results compared in order.
module tb_tpu_job_sequencer;
   localparam int DIM  = 8;
   localparam int NIN  = 16;
   localparam int NOUT = 16;
   localparam int CC   = 32;
   localparam logic [15:0] A_BASE     = 16'h100;
   localparam logic [15:0] B_BASE     = 16'h200;
   localparam logic [15:0] C_BASE     = 16'h300;
   localparam logic [15:0] START_ADDR = 16'h400;
`ifdef C_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif

   logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_last, busy, r_w;
   logic [63:0] in_data, out_data, dataIn, dataOut;
   logic [15:0] addr;

   tpu_job_sequencer dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .addr(addr), .r_w(r_w), .dataIn(dataIn), .dataOut(dataOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- tpuv1 memory-mapped model ----------------
   logic [63:0] amem [DIM];
   logic [63:0] bmem [DIM];
   logic [15:0] cm   [DIM][DIM];
   int          bptr = 0;
   bit          zero_req;

   always @(posedge clk) begin : tpuv1
      int idx, s;
      if (zero_req)
         for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) cm[r][c] = 16'h0;
      if (r_w) begin
         if (addr >= A_BASE && addr < A_BASE + 16'(8 * DIM)) begin
            idx = int'(addr - A_BASE) / 8;
            amem[idx] = dataIn;
         end else if (addr == B_BASE) begin
            bmem[bptr] = dataIn;
            bptr = (bptr + 1) % DIM;
         end else if (addr >= C_BASE && addr < C_BASE + 16'(8 * NOUT)) begin
            idx = int'(addr - C_BASE) / 8;
            for (int q = 0; q < 4; q++) cm[idx / 2][(idx % 2) * 4 + q] = dataIn[q * 16 +: 16];
         end else if (addr == START_ADDR) begin
            for (int r = 0; r < DIM; r++)
               for (int c = 0; c < DIM; c++) begin
                  s = 0;
                  for (int k = 0; k < DIM; k++)
                     s += int'($signed(amem[r][k * 8 +: 8])) * int'($signed(bmem[k][c * 8 +: 8]));
                  cm[r][c] = cm[r][c] + 16'(s);
               end
         end
      end
      if (!rst_n) bptr = 0;
   end

   always_comb begin : rd_mux
      int ri;
      ri = 0;
      dataOut = '0;
      if (addr >= C_BASE && addr < C_BASE + 16'(8 * NOUT)) begin
         ri = int'(addr - C_BASE) / 8;
         for (int q = 0; q < 4; q++) dataOut[q * 16 +: 16] = cm[ri / 2][(ri % 2) * 4 + q];
      end
   end

   // ---------------- reference model (matrix level) ----------------
   byte ja [DIM][DIM];
   byte jb [DIM][DIM];
   int  ec [DIM][DIM];

   function automatic logic [63:0] row_word(input bit is_b, input int r);
      logic [63:0] w;
      for (int c = 0; c < DIM; c++) w[c * 8 +: 8] = is_b ? jb[r][c] : ja[r][c];
      return w;
   endfunction

   function automatic logic [63:0] exp_word(input int i);
      logic [63:0] w;
      for (int q = 0; q < 4; q++) w[q * 16 +: 16] = 16'(ec[i / 2][(i % 2) * 4 + q]);
      return w;
   endfunction

   task automatic ref_mac();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            for (int k = 0; k < DIM; k++) ec[r][c] += int'(ja[r][k]) * int'(jb[k][c]);
   endtask

   task automatic ref_zero();
      for (int r = 0; r < DIM; r++) for (int c = 0; c < DIM; c++) ec[r][c] = 0;
   endtask

   task automatic randomize_job();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            ja[r][c] = byte'($urandom_range(0, 255));
            jb[r][c] = byte'($urandom_range(0, 255));
         end
   endtask

   // ---------------- bus monitor ----------------
   logic [79:0] wr_q [$];
   logic [64:0] out_q [$];
   int          cyc = 0, start_cyc = 0, rd_gap = -1;
   bit          wait_rd = 1'b0, acc_prev = 1'b0, pv = 1'b0, pr = 1'b0;
   logic [63:0] acc_dat, pdata;
   logic [15:0] paddr;
   int          rmode = 0;

   always @(negedge clk) begin
      cyc++;
      if (r_w) begin
         wr_q.push_back({addr, dataIn});
         if (addr == START_ADDR) begin
            start_cyc = cyc;
            wait_rd = 1'b1;
         end
      end
      if (!rst_n) wait_rd = 1'b0;
      if (wait_rd && !r_w && addr == C_BASE) begin
         rd_gap = cyc - start_cyc;
         wait_rd = 1'b0;
      end
      if (rst_n) begin
         if (acc_prev) check("load_write_after_accept", 80'({r_w, dataIn}), 80'({1'b1, acc_dat}));
         else if (in_ready) check("load_gap_no_write", 80'(r_w), 80'(0));
         if (pv && !pr) begin
            check("stall_addr_hold", 80'(addr), 80'(paddr));
            check("stall_data_hold", 80'({out_valid, out_data}), 80'({1'b1, pdata}));
         end
         if (out_valid && out_ready) out_q.push_back({out_last, out_data});
      end
      acc_prev = rst_n && in_valid && in_ready;
      acc_dat  = in_data;
      pv       = rst_n && out_valid;
      pr       = out_ready;
      paddr    = addr;
      pdata    = out_data;
   end

   // Result consumer: always ready, or ~30% duty when rmode is set.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = (rmode != 0) ? ($urandom_range(0, 99) < 30) : 1'b1;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   logic [63:0] got [NOUT];

   // Streams one job; abort_after>=0 asserts reset right after that word is accepted.
   task automatic run_job(input int gap, input int mode, input int abort_after, input string tag);
      logic [63:0] words [NIN];
      logic [79:0] et [$];
      int          j, b, wb, ob;
      bit          hs;
      for (int k = 0; k < NIN; k++) words[k] = row_word(k % 2 == 1, k / 2);
      wb = wr_q.size();
      ob = out_q.size();
      rmode = mode;
      rd_gap = -1;
      if (CLR) ref_zero();
      j = 0;
      b = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = words[0];
      while (j < NIN && b < 2000) begin
         @(negedge clk);
         hs = in_valid && in_ready;
         @(posedge clk);
         #1;
         b++;
         if (hs) begin
            j++;
            if (abort_after >= 0 && j == abort_after + 1) begin
               in_valid = 1'b0;
               rst_n = 1'b0;
               return;
            end
            if (j < NIN) begin
               if (gap > 0) begin
                  in_valid = 1'b0;
                  repeat (gap) begin
                     @(posedge clk);
                     #1;
                  end
               end
               in_data  = words[j];
               in_valid = 1'b1;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0;
      check({tag, "_accepted"}, 80'(j), 80'(NIN));
      ref_mac();
      b = 0;
      while (out_q.size() < ob + NOUT && b < 3000) begin
         @(posedge clk);
         b++;
      end
      check({tag, "_out_count"}, 80'(out_q.size() - ob), 80'(NOUT));
      for (int i = 0; i < NOUT && ob + i < out_q.size(); i++) begin
         got[i] = out_q[ob + i][63:0];
         check({tag, "_out_word"}, 80'(out_q[ob + i]), 80'({i == NOUT - 1, exp_word(i)}));
      end
      b = 0;
      @(negedge clk);
      while (busy !== 1'b0 && b < 100) begin
         @(negedge clk);
         b++;
      end
      check({tag, "_idle_after"}, 80'({busy, out_valid, in_ready, r_w}), 80'(0));
      if (CLR) for (int k = 0; k < NOUT; k++) et.push_back({C_BASE + 16'(8 * k), 64'h0});
      for (int k = 0; k < NIN; k++)
         et.push_back({(k % 2 == 1) ? B_BASE : (A_BASE + 16'(8 * (k / 2))), words[k]});
      et.push_back({START_ADDR, 64'h0});
      check({tag, "_trace_len"}, 80'(wr_q.size() - wb), 80'(et.size()));
      for (int k = 0; k < et.size() && wb + k < wr_q.size(); k++)
         check({tag, "_trace"}, wr_q[wb + k], et[k]);
      check({tag, "_compute_window"}, 80'(rd_gap), 80'(CC + 1));
   endtask

   int wb0;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      zero_req = 1'b1;
      ref_zero();
      repeat (2) @(posedge clk);
      @(negedge clk);
      zero_req = 1'b0;
      check("rst_in_ready", 80'(in_ready), 80'(0));
      check("rst_out_valid", 80'(out_valid), 80'(0));
      check("rst_out_data", 80'(out_data), 80'(0));
      check("rst_out_last", 80'(out_last), 80'(0));
      check("rst_busy", 80'(busy), 80'(0));
      check("rst_addr", 80'(addr), 80'(0));
      check("rst_r_w", 80'(r_w), 80'(0));
      check("rst_dataIn", 80'(dataIn), 80'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Identity A: result equals B sign-extended.
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            ja[r][c] = (r == c) ? 8'sd1 : 8'sd0;
            jb[r][c] = byte'(r * 8 + c);
         end
      run_job(0, 0, -1, "ident");
      check("ident_word0", 80'(got[0]), 80'(64'h0003_0002_0001_0000));
      check("ident_word15", 80'(got[15]), 80'(64'h003F_003E_003D_003C));

      // Random job under output backpressure, then the same job with input gaps.
      randomize_job();
      run_job(0, 1, -1, "bp");
      run_job(3, 0, -1, "gap");

      // Reset after word 5 is accepted.
      randomize_job();
      run_job(0, 0, 5, "abort");
      @(posedge clk);
      wb0 = wr_q.size();
      @(negedge clk);
      check("abort_rw_next", 80'(r_w), 80'(0));
      check("abort_busy", 80'({busy, in_ready}), 80'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      check("abort_no_write", 80'(wr_q.size() - wb0), 80'(0));
      randomize_job();
      run_job(0, 0, -1, "post_rst");

      // Accumulation: all-ones job twice starting from zeroed C.
      @(posedge clk);
      #1;
      zero_req = 1'b1;
      @(posedge clk);
      #1;
      zero_req = 1'b0;
      ref_zero();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++) begin
            ja[r][c] = 8'sd1;
            jb[r][c] = 8'sd1;
         end
      run_job(0, 0, -1, "acc1");
      run_job(0, 0, -1, "acc2");
      for (int i = 0; i < NOUT; i++)
         check("acc_second_value", 80'(got[i]), 80'({4{CLR ? 16'd8 : 16'd16}}));

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/tpu_job_sequencer.md
Name: tpu_job_sequencer

Overview:
- Upstream host-side sequencer that drives the tpuv1 memory-mapped port (addr / r_w / dataIn / dataOut).
- Accepts one matrix job as a valid/ready stream of packed 64-bit rows, then:
  - writes the A and B rows into tpuv1,
  - issues the start write,
  - waits a fixed compute window,
  - streams the C result words back out over a valid/ready output.
- Replaces hand-sequenced bus traffic between the AFU host interface and tpuv1.

Parameters:
- DIM, 8, systolic array dimension
- BITS_AB, 8, A/B element width
- BITS_C, 16, C element width
- ADDRW, 16, tpuv1 address width
- DATAW, 64, bus word width; must equal DIM*BITS_AB (elaboration-time assert)
- COMPUTE_CYCLES, 32, cycles waited after the start write before C readback
- A_BASE, 'h100, A row base; row r at A_BASE+8*r
- B_BASE, 'h200, B write address; every B row is written to this same address
- C_BASE, 'h300, C base; word i at C_BASE+8*i
- START_ADDR, 'h400, a write here starts compute

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  job word valid
- in_ready  out  1  job word accepted when in_valid && in_ready
- in_data  in  DATAW  packed row, element 0 in bits [BITS_AB-1:0]
- out_valid  out  1  result word valid
- out_ready  in  1  result consumer ready
- out_data  out  DATAW  C word; lo word holds row cols 0-3, hi word holds cols 4-7
- out_last  out  1  high with the final result word of a job
- busy  out  1  high in every state except IDLE
- addr  out  ADDRW  to tpuv1 addr
- r_w  out  1  to tpuv1 r_w; 1 = write
- dataIn  out  DATAW  to tpuv1 dataIn
- dataOut  in  DATAW  from tpuv1; combinational read of the currently presented addr

Behaviour:
- All outputs are registered. Reset values (sync, rst_n==0 at posedge): in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, addr=0, r_w=0, dataIn=0, state=IDLE, all counters 0.
- Reset asserted mid-job aborts immediately: r_w=0 on the next cycle, and no further tpuv1 writes are issued.
- Word counts: NIN=2*DIM (16); NOUT=DIM*DIM*BITS_C/DATAW (16).
- IDLE: in_ready=0. If in_valid=1, go to CLEAR (C_CLEAR_EN defined) or to LOAD. in_data is not consumed in IDLE.
- CLEAR: NOUT cycles, r_w=1, dataIn=0, addr=C_BASE+8*k for k=0..NOUT-1; then go to LOAD.
- LOAD:
  - in_ready=1 throughout. Accepted word j (0..NIN-1) is written on the following cycle (r_w=1, dataIn=word).
  - Even j goes to A_BASE+8*(j/2); odd j goes to B_BASE.
  - Cycles with no accepted word drive r_w=0, addr=0.
  - in_ready drops on the cycle after word NIN-1 is accepted. Go to START.
- START: one cycle, addr=START_ADDR, r_w=1, dataIn=0. Go to WAIT.
- WAIT: r_w=0, addr=0 for exactly COMPUTE_CYCLES cycles. Go to READ.
- READ (per word i, 0..NOUT-1):
  - Cycle 1: present addr=C_BASE+8*i, r_w=0.
  - Next edge: capture dataOut into out_data and raise out_valid.
  - Hold out_data, out_valid and addr until out_ready=1, then advance i.
  - out_last=1 with i=NOUT-1. After the final handshake, go to IDLE with out_valid=0.
  - Peak throughput is one word per 2 cycles.
- in_valid outside LOAD is ignored. out_ready outside READ is ignored.
- Address arithmetic is ADDRW bits and wraps silently; no overflow flag.
- The counters are the only state beyond the FSM; no data FIFO.

Optional Feature:
- C_CLEAR_EN defined: every job begins with the CLEAR state (NOUT zero-writes to C) before LOAD.
- C_CLEAR_EN undefined: the CLEAR state is absent, IDLE goes straight to LOAD, and results accumulate onto the existing C contents.

Test Plan:
- Reset check: assert rst_n=0 for 2 cycles -> all outputs 0, busy=0. With a tpuv1 model attached, reading C_BASE..C_BASE+'h78 returns 0.
- Identity job: C_CLEAR_EN on, A=identity, B rows with B[r][c]=r*8+c, stream 16 words with in_valid held high.
  - Write trace: 16 clears at 'h300..'h378, then A at 'h100+8r alternating with B at 'h200, then 'h400.
  - Output: 16 words equal to B sign-extended to 16 bits, out_last only on word 15.
- Backpressure: random out_ready (~30% duty) on a random 8x8 job -> words identical and in order to the golden model; addr stable while out_valid && !out_ready.
- Input gaps: in_valid deasserted for 3 cycles between every word -> writes occur only on the cycle after each acceptance; r_w=0 in the gaps; same result as the gapless run.
- Reset mid-LOAD after word 5, then a fresh job -> no write after reset; the second job's result matches the golden model.
- Accumulate: C_CLEAR_EN off, same job run twice with all A=1 and B=1 -> second job's results are all 16 (8+8).
